// File: rtl/execute_load_store_split.sv
// Load/store sequencer: turns one execute-stage memory request into one or two
// aligned bus beats, merging split load beats and lane-shifting store data.
module execute_load_store_split #(
  parameter int P_DATA_W = 32,
  parameter int P_ADDR_W = 32
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iRESET_SYNC,
  input  logic                  iREQ_VALID,
  output logic                  oREQ_BUSY,
  input  logic                  iREQ_RW,
  input  logic [1:0]            iREQ_ORDER,
  input  logic [P_ADDR_W-1:0]   iREQ_ADDR,
  input  logic [P_DATA_W-1:0]   iREQ_DATA,
  input  logic [31:0]           iREQ_PDT,
  output logic                  oMEM_REQ,
  input  logic                  iMEM_LOCK,
  output logic                  oMEM_RW,
  output logic [P_ADDR_W-1:0]   oMEM_ADDR,
  output logic [P_DATA_W-1:0]   oMEM_DATA,
  output logic [P_DATA_W/8-1:0] oMEM_MASK,
  output logic [31:0]           oMEM_PDT,
  input  logic                  iMEM_VALID,
  input  logic [P_DATA_W-1:0]   iMEM_DATA,
  output logic                  oDONE_VALID,
  output logic                  oDONE_ERR,
  output logic [P_DATA_W-1:0]   oDONE_DATA,
  output logic [2:0]            oDBG_STATE
);

  localparam int B     = P_DATA_W / 8;
  localparam int OFF_W = $clog2(B);

  typedef logic [P_ADDR_W-1:0]   addr_t;
  typedef logic [P_DATA_W-1:0]   data_t;
  typedef logic [2*P_DATA_W-1:0] data2_t;
  typedef logic [2*B-1:0]        mask2_t;

  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               rw_q, split_q, err_q;
  logic [OFF_W-1:0]   off_q;
  addr_t              addr0_q;
  data2_t             wdata_q;
  mask2_t             wmask_q;
  data_t              keep_q, rd_lo_q, rd_hi_q;
  logic [31:0]        pdt_q;

  // Request decode: everything needed for both beats is computed once at capture.
  logic [3:0]         req_size;
  logic [OFF_W-1:0]   req_off;
  logic [4:0]         req_span;
  logic               req_split, req_illegal, capture;
  mask2_t             req_mask2;
  data2_t             req_data2;
  data_t              req_keep;
  data2_t             merged;
  data_t              load_result;

  assign req_size    = 4'd1 << iREQ_ORDER;
  assign req_off     = iREQ_ADDR[OFF_W-1:0];
  assign req_span    = 5'(req_off) + 5'(req_size);
  assign req_split   = req_span > 5'(B);
  assign req_illegal = (P_DATA_W == 32) && (iREQ_ORDER == 2'd3);
  assign req_mask2   = ((mask2_t'(1) << req_size) - mask2_t'(1)) << req_off;
  assign req_data2   = data2_t'(iREQ_DATA) << {req_off, 3'b000};
  assign req_keep    = data_t'((data2_t'(1) << {req_size, 3'b000}) - data2_t'(1));
  assign capture     = (state_q == S_IDLE) && iREQ_VALID;

  // Non-split loads leave rd_hi_q at zero, so the same merge covers both cases.
  assign merged      = {rd_hi_q, rd_lo_q} >> {off_q, 3'b000};
  assign load_result = merged[P_DATA_W-1:0] & keep_q;

  assign oREQ_BUSY  = (state_q != S_IDLE);
  assign oMEM_PDT   = pdt_q;
  assign oDBG_STATE = state_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= S_IDLE;
    end else if (iRESET_SYNC) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rw_q <= 1'b0; split_q <= 1'b0; err_q <= 1'b0; off_q <= '0;
      addr0_q <= '0; wdata_q <= '0; wmask_q <= '0; keep_q <= '0;
      rd_lo_q <= '0; rd_hi_q <= '0; pdt_q <= '0;
    end else if (iRESET_SYNC) begin
      rw_q <= 1'b0; split_q <= 1'b0; err_q <= 1'b0; off_q <= '0;
      addr0_q <= '0; wdata_q <= '0; wmask_q <= '0; keep_q <= '0;
      rd_lo_q <= '0; rd_hi_q <= '0; pdt_q <= '0;
    end else begin
      if (capture) begin
        rw_q    <= iREQ_RW;
        split_q <= req_split;
        err_q   <= req_illegal;
        off_q   <= req_off;
        addr0_q <= iREQ_ADDR & ~addr_t'(B - 1);
        wdata_q <= req_data2;
        wmask_q <= req_mask2;
        keep_q  <= req_keep;
        pdt_q   <= iREQ_PDT;
        rd_lo_q <= '0;
        rd_hi_q <= '0;
      end
      if (state_q == S_WAIT0 && iMEM_VALID) rd_lo_q <= iMEM_DATA;
      if (state_q == S_WAIT1 && iMEM_VALID) rd_hi_q <= iMEM_DATA;
    end
  end

  // Handshake: a beat is accepted when oMEM_REQ=1 and iMEM_LOCK=0; the beat's
  // addr/data/mask hold until then, and exactly one iMEM_VALID answers it.
  always_comb begin
    state_d     = state_q;
    oMEM_REQ    = 1'b0;
    oMEM_RW     = 1'b0;
    oMEM_ADDR   = '0;
    oMEM_DATA   = '0;
    oMEM_MASK   = '0;
    oDONE_VALID = 1'b0;
    oDONE_ERR   = 1'b0;
    oDONE_DATA  = '0;
    case (state_q)
      S_IDLE: begin
        if (iREQ_VALID) state_d = req_illegal ? S_DONE : S_REQ0;
      end
      S_REQ0: begin
        oMEM_REQ  = 1'b1;
        oMEM_RW   = rw_q;
        oMEM_ADDR = addr0_q;
        oMEM_DATA = wdata_q[P_DATA_W-1:0];
        oMEM_MASK = wmask_q[B-1:0];
        if (!iMEM_LOCK) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (iMEM_VALID) state_d = split_q ? S_REQ1 : S_DONE;
      end
      S_REQ1: begin
        oMEM_REQ  = 1'b1;
        oMEM_RW   = rw_q;
        oMEM_ADDR = addr0_q + addr_t'(B);
        oMEM_DATA = wdata_q[2*P_DATA_W-1:P_DATA_W];
        oMEM_MASK = wmask_q[2*B-1:B];
        if (!iMEM_LOCK) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (iMEM_VALID) state_d = S_DONE;
      end
      S_DONE: begin
        oDONE_VALID = 1'b1;
        oDONE_ERR   = err_q;
        oDONE_DATA  = (rw_q || err_q) ? '0 : load_result;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_execute_load_store_split.sv
// Directed and random bench for execute_load_store_split against a byte-level
// memory model with a zero-wait responder and controllable lock stalls.
module tb_execute_load_store_split;
  localparam int W = 32;
  localparam int B = 4;

  // ---- clock / reset ----
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_sync;
  logic          req_valid, req_rw;
  logic [1:0]    req_order;
  logic [31:0]   req_addr, req_pdt;
  logic [W-1:0]  req_data;
  logic          mem_lock = 1'b0;
  logic          mem_valid = 1'b0;
  logic [W-1:0]  mem_rdata = '0;
  logic          o_req_busy, o_mem_req, o_mem_rw, o_done_valid, o_done_err;
  logic [31:0]   o_mem_addr, o_mem_pdt;
  logic [W-1:0]  o_mem_data, o_done_data;
  logic [B-1:0]  o_mem_mask;
  logic [2:0]    dbg_state;

  execute_load_store_split #(.P_DATA_W(W), .P_ADDR_W(32)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
    .iREQ_VALID(req_valid), .oREQ_BUSY(o_req_busy), .iREQ_RW(req_rw),
    .iREQ_ORDER(req_order), .iREQ_ADDR(req_addr), .iREQ_DATA(req_data),
    .iREQ_PDT(req_pdt), .oMEM_REQ(o_mem_req), .iMEM_LOCK(mem_lock),
    .oMEM_RW(o_mem_rw), .oMEM_ADDR(o_mem_addr), .oMEM_DATA(o_mem_data),
    .oMEM_MASK(o_mem_mask), .oMEM_PDT(o_mem_pdt), .iMEM_VALID(mem_valid),
    .iMEM_DATA(mem_rdata), .oDONE_VALID(o_done_valid), .oDONE_ERR(o_done_err),
    .oDONE_DATA(o_done_data), .oDBG_STATE(dbg_state)
  );

  // ---- scoreboard state ----
  int total = 0;
  int bad = 0;
  logic [7:0]    mem [logic [31:0]];
  logic [W-1:0]  exp_q [$];
  logic [31:0]   obs_a_q [$];
  logic [B-1:0]  obs_m_q [$];
  logic [W-1:0]  obs_d_q [$];
  logic          obs_rw_q [$];

  int beat_total = 0, served = 0, txn_base = 0, resp_max = 2;
  int stray_req = 0, stray_ack = 0, lock_plan = 0, lock_used = 0;
  int unstable_cnt = 0, locked_cycles = 0;
  logic          prev_locked = 1'b0;
  logic [68:0]   snap = '0;
  logic [W-1:0]  resp_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  // ---- bus monitor: records accepted beats, checks stability under lock ----
  always @(negedge clk) begin
    if (o_mem_req) begin
      if (prev_locked && ({o_mem_addr, o_mem_data, o_mem_mask, o_mem_rw} != snap))
        unstable_cnt++;
      snap = {o_mem_addr, o_mem_data, o_mem_mask, o_mem_rw};
      prev_locked = mem_lock;
      if (mem_lock) begin
        locked_cycles++;
      end else begin
        obs_a_q.push_back(o_mem_addr);
        obs_m_q.push_back(o_mem_mask);
        obs_d_q.push_back(o_mem_data);
        obs_rw_q.push_back(o_mem_rw);
        for (int j = 0; j < B; j++) resp_data[8*j +: 8] = mem_rd(o_mem_addr + 32'(j));
        beat_total++;
      end
    end else begin
      prev_locked = 1'b0;
    end
  end

  // ---- bus responder: valid one cycle after acceptance, optional stalls ----
  always @(posedge clk) begin
    #1;
    mem_valid = 1'b0;
    mem_rdata = '0;
    if (served != beat_total) begin
      served = beat_total;
      if (beat_total - txn_base <= resp_max) begin
        mem_valid = 1'b1;
        mem_rdata = resp_data;
      end
    end else if (stray_ack != stray_req) begin
      stray_ack = stray_req;
      mem_valid = 1'b1;
      mem_rdata = '1;
    end
    if (o_mem_req && (beat_total - txn_base == 1) && (lock_used < lock_plan)) begin
      mem_lock = 1'b1;
      lock_used++;
    end else begin
      mem_lock = 1'b0;
    end
  end

  // ---- drivers ----
  task automatic drive_req(input logic rw, input logic [1:0] order, input logic [31:0] addr,
                           input logic [W-1:0] data, input logic [31:0] pdt);
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = rw; req_order = order;
    req_addr = addr; req_data = data; req_pdt = pdt;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_req_busy), 0);
    chk({tag, "_mem_req"}, 64'(o_mem_req), 0);
    chk({tag, "_mem_rw"}, 64'(o_mem_rw), 0);
    chk({tag, "_mem_addr"}, 64'(o_mem_addr), 0);
    chk({tag, "_mem_data"}, 64'(o_mem_data), 0);
    chk({tag, "_mem_mask"}, 64'(o_mem_mask), 0);
    chk({tag, "_mem_pdt"}, 64'(o_mem_pdt), 0);
    chk({tag, "_done"}, 64'(o_done_valid), 0);
    chk({tag, "_err"}, 64'(o_done_err), 0);
    chk({tag, "_done_data"}, 64'(o_done_data), 0);
  endtask

  // One full transaction: byte-level model builds the expected beats and result.
  task automatic do_txn(input logic rw, input logic [1:0] order, input logic [31:0] addr,
                        input logic [W-1:0] data, input int lock_n, output logic [W-1:0] got);
    int size, nb, exp_lat, n, lane;
    logic err, got_done;
    logic [31:0] ea [2];
    logic [B-1:0] em [2];
    logic [W-1:0] ed [2];
    logic [W-1:0] res;
    logic [31:0] a, w, pdt;
    size = 1 << order;
    err = (order == 2'd3);
    nb = 0; res = '0;
    for (int k = 0; k < 2; k++) begin ea[k] = '0; em[k] = '0; ed[k] = '0; end
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        a = addr + 32'(i);
        w = {a[31:2], 2'b00};
        lane = int'(a[1:0]);
        if (nb == 0 || ea[nb-1] != w) begin ea[nb] = w; nb++; end
        em[nb-1][lane] = 1'b1;
        if (rw) ed[nb-1][8*lane +: 8] = data[8*i +: 8];
        else res[8*i +: 8] = mem_rd(a);
      end
    end
    exp_q.push_back((rw || err) ? '0 : res);
    exp_lat = err ? 2 : ((nb == 2) ? 6 + lock_n : 4);
    pdt = $urandom;
    txn_base = beat_total;
    lock_plan = lock_used + lock_n;
    drive_req(rw, order, addr, data, pdt);
    n = 0; got_done = 1'b0;
    while (n < 100 && !got_done) begin
      @(negedge clk); n++;
      if (o_done_valid) got_done = 1'b1;
      else begin
        if (n == 1) chk("busy_req_cycle", 64'(o_req_busy), 0);
        if (n == 2) chk("busy_in_flight", 64'(o_req_busy), 1);
        if (n == 1) begin @(posedge clk); #1 req_valid = 1'b0; end
      end
    end
    req_valid = 1'b0;
    chk("done_seen", 64'(got_done), 1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("done_err", 64'(o_done_err), 64'(err));
    chk("mem_pdt", 64'(o_mem_pdt), 64'(pdt));
    got = o_done_data;
    chk("done_data", 64'(o_done_data), 64'(exp_q.pop_front()));
    chk("beat_count", 64'(beat_total - txn_base), 64'(nb));
    for (int k = 0; k < nb; k++) begin
      if (txn_base + k < obs_a_q.size()) begin
        chk("beat_addr", 64'(obs_a_q[txn_base+k]), 64'(ea[k]));
        chk("beat_mask", 64'(obs_m_q[txn_base+k]), 64'(em[k]));
        chk("beat_data", 64'(obs_d_q[txn_base+k]), 64'(ed[k]));
        chk("beat_rw", 64'(obs_rw_q[txn_base+k]), 64'(rw));
      end
    end
    if (rw && !err)
      for (int i = 0; i < size; i++) mem[addr + 32'(i)] = data[8*i +: 8];
    @(negedge clk);
    chk("busy_after_done", 64'(o_req_busy), 0);
    chk("single_done_pulse", 64'(o_done_valid), 0);
  endtask

  // ---- stimulus ----
  initial begin
    logic [W-1:0] got;
    int lc0, n, done_seen, size;
    logic rw;
    logic [1:0] order;
    logic [W-1:0] data;
    rst_n = 1'b0; rst_sync = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
    req_order = '0; req_addr = '0; req_data = '0; req_pdt = '0;
    mem[32'h1000] = 8'haa; mem[32'h1001] = 8'hbb; mem[32'h1002] = 8'hcc; mem[32'h1003] = 8'hdd;
    mem[32'h1004] = 8'h11; mem[32'h1005] = 8'h22; mem[32'h1006] = 8'h33; mem[32'h1007] = 8'h44;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chk("reset_state", 64'(dbg_state), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Load8 inside one word.
    do_txn(1'b0, 2'd0, 32'h1001, '0, 0, got);
    chk("tp_load8_data", 64'(got), 64'h000000bb);
    chk("tp_load8_mask", 64'(obs_m_q[txn_base]), 64'(4'b0010));
    // Load32 split across two words.
    do_txn(1'b0, 2'd2, 32'h1002, '0, 0, got);
    chk("tp_load32_data", 64'(got), 64'h2211ddcc);
    // Store16 split.
    do_txn(1'b1, 2'd1, 32'h1003, 32'h0000beef, 0, got);
    chk("tp_store_data0", 64'(obs_d_q[txn_base]), 64'hef000000);
    chk("tp_store_data1", 64'(obs_d_q[txn_base+1]), 64'h000000be);
    chk("tp_store_result", 64'(got), 0);
    // Lock held for 3 cycles on beat 1.
    lc0 = locked_cycles;
    do_txn(1'b0, 2'd2, 32'h1002, '0, 3, got);
    chk("lock_cycles", 64'(locked_cycles - lc0), 3);
    chk("lock_stable", 64'(unstable_cnt), 0);
    // Illegal 64-bit order on a 32-bit bus.
    do_txn(1'b0, 2'd3, 32'h1000, '0, 0, got);
    // Address wrap on beat 1.
    do_txn(1'b0, 2'd1, 32'hffffffff, '0, 0, got);
    chk("wrap_beat1_addr", 64'(obs_a_q[txn_base+1]), 0);

    // Async reset while waiting for beat 1, then a stray response.
    resp_max = 1;
    txn_base = beat_total;
    drive_req(1'b0, 2'd2, 32'h1002, '0, 32'h1234);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (n < 50 && beat_total - txn_base < 2) begin @(negedge clk); n++; end
    chk("reach_beat1", 64'(beat_total - txn_base), 2);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    @(posedge clk); #2 rst_n = 1'b1;
    stray_req++;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done_valid || o_req_busy) done_seen++;
    end
    chk("stray_valid_ignored", 64'(done_seen), 0);
    resp_max = 2;
    do_txn(1'b0, 2'd2, 32'h2000, '0, 0, got);

    // Synchronous clear while waiting for beat 0.
    resp_max = 0;
    txn_base = beat_total;
    drive_req(1'b0, 2'd0, 32'h1001, '0, 32'h5555);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (n < 50 && beat_total - txn_base < 1) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst_sync = 1'b1;
    @(posedge clk); #1 rst_sync = 1'b0;
    @(negedge clk);
    check_all_zero("sync_clear");
    resp_max = 2;

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom_range(0, 1));
      order = 2'($urandom_range(0, 3));
      size = 1 << order;
      data = $urandom;
      if (size < 4) data = data & ((32'd1 << (8 * size)) - 32'd1);
      if (!rw) data = '0;
      do_txn(rw, order, 32'h3000 + 32'($urandom_range(0, 63)), data,
             $urandom_range(0, 2), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
